decoder_fsm: RTL and testbench
==============================

# decoder_fsm

Parametrised instruction-sequencing control unit for bb_core, the next generation of the core decoder. It sequences fetch, decode and execute and drives the per-unit one-hot register enables, the memory action and the address source. Over the previous generation it adds:

- configurable unit count and data width;
- a memory ready handshake with wait states;
- a halt/resume mechanism;
- a memory-timeout error trap.

It sits between the IR/register file/ALU datapath and the memory port.

## Interface
Parameters:
- DATA_WIDTH, 8, instruction/data width; must be ≥ UNIT_BITS+3
- UNIT_COUNT, 6, number of addressable datapath units (one-hot enable width)
- UNIT_BITS, 3, unit index field width; must satisfy 2^UNIT_BITS > UNIT_COUNT
- IR_UNIT, 1, unit index of the instruction register
- PC_UNIT, 6, unit index of the program counter
- TIMEOUT, 16, wait cycles before memory timeout; 0 disables the timeout
- TO_WIDTH, 5, timeout counter width; must satisfy 2^TO_WIDTH > TIMEOUT

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_ir  in  DATA_WIDTH  current instruction register contents
- i_mem_ready  in  1  memory has completed the current read/write this cycle
- i_resume  in  1  leave HALT (level sampled on clk)
- o_mem_action  out  2  00 PAUSE, 01 READ, 10 WRITE
- o_unit_reg_input_en  out  UNIT_COUNT  one-hot load enable (bit u-1 = unit u)
- o_unit_reg_output_en  out  UNIT_COUNT  one-hot register drive-bus enable
- o_unit_alu_output_en  out  UNIT_COUNT  one-hot ALU-result drive enable
- o_mem_addr_source  out  1  0 = PC, 1 = AR
- o_pc_counter_en  out  1  PC increment strobe
- o_halted  out  1  state == HALT
- o_error  out  1  state == ERROR (sticky)
- o_state  out  3  current state encoding, for debug

## Operation
Instruction fields:
- act = i_ir[DW-1:DW-2]: 00 PAUSE, 01 WRITE, 10 READ_PC, 11 READ_AR
- alu = i_ir[DW-3]
- unit = i_ir[UNIT_BITS-1:0]
- Unit index 0 or > UNIT_COUNT decodes to an all-zero one-hot; the memory transaction is still performed.

States: IDLE=0, FETCH=1, DECODE=2, READ=3, WRITE=4, HALT=5, ERROR=6. Outputs are combinational from the state and latched fields, with no glitch paths from i_ir outside DECODE.

- **IDLE:** mem_action PAUSE, all enables 0, addr_src 1. Next state FETCH.
- **FETCH:** READ, addr_src 0, input_en = onehot(IR_UNIT), pc_counter_en = i_mem_ready.
  - Ready → DECODE.
  - Not ready → stay.
- **DECODE:** PAUSE, all enables 0. Latches act, alu and unit from i_ir.
  - READ_PC → READ with latched src 0.
  - READ_AR → READ with latched src 1.
  - WRITE → WRITE.
  - PAUSE with unit == PC_UNIT → FETCH (NOP).
  - Other PAUSE → HALT.
- **READ:** READ, addr_src = latched src, input_en = onehot(unit), pc_counter_en = i_mem_ready & (src == 0).
  - Ready and unit == IR_UNIT → DECODE (chained load).
  - Ready otherwise → FETCH.
- **WRITE:** WRITE, addr_src 1.
  - If alu = 1, alu_output_en = onehot(unit); otherwise reg_output_en = onehot(unit).
  - Ready → FETCH.
- **HALT:** PAUSE, all enables 0, o_halted 1. i_resume → FETCH.
- **ERROR:** PAUSE, all enables 0, o_error 1. Left only by reset.

Timeout:
- The counter clears on every state change.
- It increments each FETCH/READ/WRITE cycle with i_mem_ready = 0.
- When the count equals TIMEOUT-1 and ready is still 0, the next state is ERROR.
- Ready in that same cycle wins: the transaction completes normally.

Boundary rules:
- i_mem_ready is ignored outside FETCH, READ and WRITE.
- i_resume is ignored outside HALT.
- Reset asserted mid-transaction returns to IDLE immediately (async); outputs take IDLE values in the same instant.

## Timing
- All state and latched fields update on posedge clk; rst_n is asynchronous assert and synchronous-safe deassert.
- Reset values: state IDLE, latched fields 0, timeout counter 0. Outputs are o_mem_action 00, all enables 0, o_mem_addr_source 1, o_pc_counter_en 0, o_halted 0, o_error 0, o_state 0.
- Zero-wait read/write instruction takes 3 cycles (FETCH, DECODE, READ/WRITE). Each wait cycle adds 1.
- First FETCH occurs 1 cycle after reset release.
- pc_counter_en is high only in the cycle where ready is high.

## Structure
- Add to define.v:
  - action codes
  - mem action codes
  - addr source codes
  - decoder_fsm state encodings
- Sub-module unit_onehot_dec, parameterised by UNIT_COUNT and UNIT_BITS: index → one-hot with NULL for 0/out of range. It is instantiated once on the latched unit; the IR_UNIT constant uses a localparam.
- Timeout counter stays inline.

## Test plan
- **Reset, then ready held 1:** cycle 1 FETCH with input_en 6'b000001 and pc_counter_en 1. i_ir = 8'b10_0_00011 → DECODE, then READ with input_en 6'b000100, addr_src 0, pc_counter_en 1, then FETCH.
- **WRITE via ALU:** i_ir = 8'b01_1_00100, ready held 0 for 3 cycles. WRITE persists 4 cycles with alu_output_en 6'b001000, reg_output_en 0, mem_action 10.
- **READ_AR into IR:** i_ir = 8'b11_0_00001. READ is followed directly by DECODE (no FETCH); pc_counter_en stays 0 throughout READ.
- **Halt and resume:** i_ir = 8'b00_0_00011 → HALT, o_halted 1. i_resume pulsed in READ earlier has no effect; i_resume in HALT → FETCH next cycle.
- **Timeout:** with TIMEOUT = 4 and ready held 0 in FETCH, ERROR is entered after 4 FETCH cycles with o_error 1. i_resume and ready ignored; only rst_n clears it.
- **Async reset mid-WRITE:** outputs return to the reset values without a clock edge; FETCH follows 1 cycle after release.

Source files
------------

// File: rtl/decoder_fsm_pkg.sv
// decoder_fsm_pkg: shared encodings for the bb_core instruction sequencer.
package decoder_fsm_pkg;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_READ   = 3'd3,
        S_WRITE  = 3'd4,
        S_HALT   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;
    typedef enum logic [1:0] {
        ACT_PAUSE   = 2'b00,
        ACT_WRITE   = 2'b01,
        ACT_READ_PC = 2'b10,
        ACT_READ_AR = 2'b11
    } act_t;
    localparam logic [1:0] MEM_PAUSE = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;
    localparam logic ADDR_PC = 1'b0;
    localparam logic ADDR_AR = 1'b1;
endpackage

// File: rtl/decoder_fsm_unit_onehot_dec.sv
// unit_onehot_dec: unit index to one-hot enable; index 0 or out of range gives all zeros.
module unit_onehot_dec #(
    parameter int UNIT_COUNT = 6,
    parameter int UNIT_BITS  = 3
) (
    input  logic [UNIT_BITS-1:0]  unit,
    output logic [UNIT_COUNT-1:0] onehot
);
    always_comb begin
        onehot = '0;
        for (int i = 1; i <= UNIT_COUNT; i++) onehot[i-1] = (unit == UNIT_BITS'(i));
    end
endmodule

// File: rtl/decoder_fsm.sv
// decoder_fsm: fetch/decode/execute sequencer with memory wait states, halt/resume and timeout trap.
module decoder_fsm
    import decoder_fsm_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int UNIT_COUNT = 6,
    parameter int UNIT_BITS  = 3,
    parameter int IR_UNIT    = 1,
    parameter int PC_UNIT    = 6,
    parameter int TIMEOUT    = 16,
    parameter int TO_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_ir,
    input  logic                  i_mem_ready,
    input  logic                  i_resume,
    output logic [1:0]            o_mem_action,
    output logic [UNIT_COUNT-1:0] o_unit_reg_input_en,
    output logic [UNIT_COUNT-1:0] o_unit_reg_output_en,
    output logic [UNIT_COUNT-1:0] o_unit_alu_output_en,
    output logic                  o_mem_addr_source,
    output logic                  o_pc_counter_en,
    output logic                  o_halted,
    output logic                  o_error,
    output logic [2:0]            o_state
);
    localparam logic [UNIT_COUNT-1:0] IR_OH = (IR_UNIT >= 1 && IR_UNIT <= UNIT_COUNT) ?
        UNIT_COUNT'(1) << (IR_UNIT - 1) : '0;

    state_t                  st, nxt;
    act_t                    act;
    logic                    alu;
    logic [UNIT_BITS-1:0]    unit;
    logic [TO_WIDTH-1:0]     cnt;
    logic [UNIT_COUNT-1:0]   unit_oh;
    logic [1:0]              ir_act;
    logic                    mem_st, timeout;

    assign ir_act = i_ir[DATA_WIDTH-1:DATA_WIDTH-2];

    unit_onehot_dec #(.UNIT_COUNT(UNIT_COUNT), .UNIT_BITS(UNIT_BITS)) u_dec (
        .unit(unit),
        .onehot(unit_oh)
    );

    always_comb begin
        mem_st = st inside {S_FETCH, S_READ, S_WRITE};
        timeout = (TIMEOUT != 0) && (cnt == TO_WIDTH'(TIMEOUT - 1)) && !i_mem_ready;
        nxt = st;
        case (st)
            S_IDLE:   nxt = S_FETCH;
            S_FETCH:  nxt = i_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: nxt = ir_act[1] ? S_READ : ir_act[0] ? S_WRITE :
                            (i_ir[UNIT_BITS-1:0] == UNIT_BITS'(PC_UNIT)) ? S_FETCH : S_HALT;
            S_READ:   nxt = !i_mem_ready ? S_READ :
                            (unit == UNIT_BITS'(IR_UNIT)) ? S_DECODE : S_FETCH;
            S_WRITE:  nxt = i_mem_ready ? S_FETCH : S_WRITE;
            S_HALT:   nxt = i_resume ? S_FETCH : S_HALT;
            default:  nxt = S_ERROR;
        endcase
        if (mem_st && timeout) nxt = S_ERROR;
    end

    // Staying in a memory state implies ready was low, so the wait count only needs mem_st.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= S_IDLE;
            act  <= ACT_PAUSE;
            alu  <= 1'b0;
            unit <= '0;
            cnt  <= '0;
        end else begin
            st  <= nxt;
            cnt <= (nxt == st) ? cnt + TO_WIDTH'(mem_st) : '0;
            if (st == S_DECODE) begin
                act  <= act_t'(ir_act);
                alu  <= i_ir[DATA_WIDTH-3];
                unit <= i_ir[UNIT_BITS-1:0];
            end
        end
    end

    always_comb begin
        o_mem_action         = MEM_PAUSE;
        o_unit_reg_input_en  = '0;
        o_unit_reg_output_en = '0;
        o_unit_alu_output_en = '0;
        o_mem_addr_source    = ADDR_AR;
        o_pc_counter_en      = 1'b0;
        case (st)
            S_FETCH: begin
                o_mem_action        = MEM_READ;
                o_mem_addr_source   = ADDR_PC;
                o_unit_reg_input_en = IR_OH;
                o_pc_counter_en     = i_mem_ready;
            end
            S_READ: begin
                o_mem_action        = MEM_READ;
                o_mem_addr_source   = act[0];
                o_unit_reg_input_en = unit_oh;
                o_pc_counter_en     = i_mem_ready && !act[0];
            end
            S_WRITE: begin
                o_mem_action         = MEM_WRITE;
                o_unit_alu_output_en = alu ? unit_oh : '0;
                o_unit_reg_output_en = alu ? '0 : unit_oh;
            end
            default: ;
        endcase
    end

    assign o_halted = (st == S_HALT);
    assign o_error  = (st == S_ERROR);
    assign o_state  = st;
endmodule

// File: tb/tb_decoder_fsm.sv
// tb_decoder_fsm: directed scoreboard bench for decoder_fsm with TIMEOUT = 4.
module tb_decoder_fsm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ir = '0;
    logic       ready = 1'b0;
    logic       resume = 1'b0;
    logic [1:0] mem_action;
    logic [5:0] reg_in, reg_out, alu_out;
    logic       addr_src, pc_en, halted, error;
    logic [2:0] state;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] mem;
        logic [5:0] ien, ro, ao;
        logic       addr, pc, halt, err;
    } out_t;
    typedef struct {
        string tag;
        out_t  ex;
    } sb_t;

    sb_t q[$];
    int  compared = 0;
    int  mismatched = 0;

    always #5 clk = ~clk;

    decoder_fsm #(
        .DATA_WIDTH(8), .UNIT_COUNT(6), .UNIT_BITS(3), .IR_UNIT(1),
        .PC_UNIT(6), .TIMEOUT(4), .TO_WIDTH(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_ir(ir), .i_mem_ready(ready), .i_resume(resume),
        .o_mem_action(mem_action), .o_unit_reg_input_en(reg_in),
        .o_unit_reg_output_en(reg_out), .o_unit_alu_output_en(alu_out),
        .o_mem_addr_source(addr_src), .o_pc_counter_en(pc_en),
        .o_halted(halted), .o_error(error), .o_state(state)
    );

    function automatic out_t e(input logic [2:0] st, input logic [1:0] mem, input logic [5:0] ien,
                               input logic [5:0] ro, input logic [5:0] ao, input logic addr, input logic pc);
        return '{st: st, mem: mem, ien: ien, ro: ro, ao: ao, addr: addr, pc: pc,
                 halt: (st == 3'd5), err: (st == 3'd6)};
    endfunction

    task automatic expect_out(input string tag, input out_t ex);
        q.push_back('{tag: tag, ex: ex});
    endtask

    task automatic check_out();
        sb_t  s;
        out_t obs;
        s = q.pop_front();
        obs = '{st: state, mem: mem_action, ien: reg_in, ro: reg_out, ao: alu_out,
                addr: addr_src, pc: pc_en, halt: halted, err: error};
        compared++;
        assert (obs === s.ex) else begin
            mismatched++;
            $error("FAIL %s: got st=%0d mem=%b in=%b ro=%b ao=%b addr=%b pc=%b h=%b e=%b, want st=%0d mem=%b in=%b ro=%b ao=%b addr=%b pc=%b h=%b e=%b",
                   s.tag, obs.st, obs.mem, obs.ien, obs.ro, obs.ao, obs.addr, obs.pc, obs.halt, obs.err,
                   s.ex.st, s.ex.mem, s.ex.ien, s.ex.ro, s.ex.ao, s.ex.addr, s.ex.pc, s.ex.halt, s.ex.err);
        end
    endtask

    task automatic step(input string tag, input logic [7:0] ir_v, input logic rdy, input logic res, input out_t ex);
        ir = ir_v;
        ready = rdy;
        resume = res;
        expect_out(tag, ex);
        #1;
        check_out();
        @(negedge clk);
    endtask

    initial begin
        ready = 1'b1;
        #2;
        expect_out("reset", e(0, 2'b00, 0, 0, 0, 1, 0));
        check_out();
        @(negedge clk);
        rst_n = 1'b1;
        step("idle",     8'h00,        1, 0, e(0, 2'b00, 0, 0, 0, 1, 0));
        step("fetch1",   8'h00,        1, 0, e(1, 2'b01, 6'b000001, 0, 0, 0, 1));
        step("dec_rdpc", 8'b10_0_00011, 1, 0, e(2, 2'b00, 0, 0, 0, 1, 0));
        step("read_pc",  8'b00_0_00000, 1, 0, e(3, 2'b01, 6'b000100, 0, 0, 0, 1));
        step("fetch2",   8'h00,        1, 0, e(1, 2'b01, 6'b000001, 0, 0, 0, 1));
        step("dec_wr",   8'b01_1_00100, 1, 0, e(2, 2'b00, 0, 0, 0, 1, 0));
        step("wr_w0",    8'h00,        0, 0, e(4, 2'b10, 0, 0, 6'b001000, 1, 0));
        step("wr_w1",    8'h00,        0, 0, e(4, 2'b10, 0, 0, 6'b001000, 1, 0));
        step("wr_w2",    8'h00,        0, 0, e(4, 2'b10, 0, 0, 6'b001000, 1, 0));
        step("wr_done",  8'h00,        1, 0, e(4, 2'b10, 0, 0, 6'b001000, 1, 0));
        step("fetch3",   8'h00,        1, 0, e(1, 2'b01, 6'b000001, 0, 0, 0, 1));
        step("dec_rdar", 8'b11_0_00001, 1, 0, e(2, 2'b00, 0, 0, 0, 1, 0));
        step("rdar_w",   8'h00,        0, 1, e(3, 2'b01, 6'b000001, 0, 0, 1, 0));
        step("rdar",     8'h00,        1, 0, e(3, 2'b01, 6'b000001, 0, 0, 1, 0));
        step("dec_halt", 8'b00_0_00011, 1, 0, e(2, 2'b00, 0, 0, 0, 1, 0));
        step("halt0",    8'h00,        1, 0, e(5, 2'b00, 0, 0, 0, 1, 0));
        step("halt1",    8'h00,        1, 0, e(5, 2'b00, 0, 0, 0, 1, 0));
        step("halt_res", 8'h00,        0, 1, e(5, 2'b00, 0, 0, 0, 1, 0));
        step("fetch4",   8'h00,        1, 0, e(1, 2'b01, 6'b000001, 0, 0, 0, 1));
        step("dec_nop",  8'b00_0_00110, 1, 0, e(2, 2'b00, 0, 0, 0, 1, 0));
        step("fetch5",   8'h00,        1, 0, e(1, 2'b01, 6'b000001, 0, 0, 0, 1));
        step("dec_u7",   8'b10_0_00111, 1, 0, e(2, 2'b00, 0, 0, 0, 1, 0));
        step("read_u7",  8'h00,        1, 0, e(3, 2'b01, 0, 0, 0, 0, 1));
        step("to_f0",    8'h00,        0, 0, e(1, 2'b01, 6'b000001, 0, 0, 0, 0));
        step("to_f1",    8'h00,        0, 0, e(1, 2'b01, 6'b000001, 0, 0, 0, 0));
        step("to_f2",    8'h00,        0, 0, e(1, 2'b01, 6'b000001, 0, 0, 0, 0));
        step("to_f3",    8'h00,        0, 0, e(1, 2'b01, 6'b000001, 0, 0, 0, 0));
        step("err0",     8'h00,        1, 1, e(6, 2'b00, 0, 0, 0, 1, 0));
        step("err1",     8'b10_0_00011, 1, 1, e(6, 2'b00, 0, 0, 0, 1, 0));
        rst_n = 1'b0;
        expect_out("err_reset", e(0, 2'b00, 0, 0, 0, 1, 0));
        #1;
        check_out();
        @(negedge clk);
        rst_n = 1'b1;
        step("idle2",    8'h00,        1, 0, e(0, 2'b00, 0, 0, 0, 1, 0));
        step("fetch6",   8'h00,        1, 0, e(1, 2'b01, 6'b000001, 0, 0, 0, 1));
        step("dec_wr2",  8'b01_0_00010, 1, 0, e(2, 2'b00, 0, 0, 0, 1, 0));
        step("wr_reg",   8'h00,        0, 0, e(4, 2'b10, 0, 6'b000010, 0, 1, 0));
        #2;
        rst_n = 1'b0;
        expect_out("async_rst", e(0, 2'b00, 0, 0, 0, 1, 0));
        #1;
        check_out();
        @(negedge clk);
        rst_n = 1'b1;
        step("idle3",    8'h00,        0, 0, e(0, 2'b00, 0, 0, 0, 1, 0));
        step("fetch7",   8'h00,        0, 0, e(1, 2'b01, 6'b000001, 0, 0, 0, 0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
